// File: rtl/udma_spim_cfg_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : udma_spim_cfg_seq_if
// Purpose  : uDMA SPI-master cfg register bus between an initiator
//            (udma_spim_cfg_seq) and the register responder (udma_spim_reg_if).
// Signals  : cfg_valid_o  initiator request
//            cfg_rwn_o    1=read 0=write
//            cfg_addr_o   5-bit register address
//            cfg_data_o   write data
//            cfg_data_i   read data from responder
//            cfg_ready_i  responder ready; a transaction completes on a rising
//                         edge where cfg_valid_o & cfg_ready_i
// Revision : 1.0  initial release
// ============================================================================
interface udma_spim_cfg_seq_if;
  logic        cfg_valid_o;
  logic        cfg_rwn_o;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_i;

  modport master (
    output cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o,
    input  cfg_data_i, cfg_ready_i
  );

  modport slave (
    input  cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o,
    output cfg_data_i, cfg_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/udma_spim_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : udma_spim_cfg_seq
// Purpose  : Programs one uDMA SPI-master channel (CMD/RX/TX) from a single
//            descriptor: writes SADDR, SIZE and CFG(en), then optionally polls
//            the channel CFG register until en and pending both clear.
// Ports    : clk_i, rst_i        clock, synchronous active-high reset
//            req_*               descriptor handshake (valid/ready) and fields
//            done_valid_o/err_o  one-cycle completion pulse with error flag
//            busy_o              sequencer not idle
//            cfg (master)        cfg register bus initiator
// Revision : 1.0  initial release
// ============================================================================
module udma_spim_cfg_seq #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int POLL_GAP       = 4,
  parameter int POLL_MAX       = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_chan_i,
  input  logic [L2_AWIDTH_NOAL-1:0] req_addr_i,
  input  logic [TRANS_SIZE-1:0]     req_size_i,
  input  logic [1:0]                req_datasize_i,
  input  logic                      req_wait_i,
  output logic                      done_valid_o,
  output logic                      done_err_o,
  output logic                      busy_o,
  udma_spim_cfg_seq_if.master       cfg
);

  // Register map of udma_spim_reg_if
  localparam logic [4:0] c_REG_RX_SADDR  = 5'h00;
  localparam logic [4:0] c_REG_RX_SIZE   = 5'h01;
  localparam logic [4:0] c_REG_RX_CFG    = 5'h02;
  localparam logic [4:0] c_REG_TX_SADDR  = 5'h04;
  localparam logic [4:0] c_REG_TX_SIZE   = 5'h05;
  localparam logic [4:0] c_REG_TX_CFG    = 5'h06;
  localparam logic [4:0] c_REG_CMD_SADDR = 5'h08;
  localparam logic [4:0] c_REG_CMD_SIZE  = 5'h09;
  localparam logic [4:0] c_REG_CMD_CFG   = 5'h0A;

  localparam logic [1:0] c_CHAN_CMD     = 2'd0;
  localparam logic [1:0] c_CHAN_RX      = 2'd1;
  localparam logic [1:0] c_CHAN_TX      = 2'd2;
  localparam logic [1:0] c_CHAN_ILLEGAL = 2'd3;

  localparam int c_PW = $clog2(POLL_MAX + 1);
  // A zero-width counter is not legal, so a gap-less build keeps one bit.
  localparam int c_GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [c_PW-1:0] c_POLL_LAST = c_PW'(POLL_MAX - 1);
  localparam logic [c_PW-1:0] c_POLL_SAT  = c_PW'(POLL_MAX);
  localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam bit              c_HAS_GAP   = (POLL_GAP > 0);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_SADDR = 3'd1,
    ST_WR_SIZE  = 3'd2,
    ST_WR_CFG   = 3'd3,
    ST_POLL_RD  = 3'd4,
    ST_GAP      = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_err_nxt;
  logic                      r_err;
  logic [1:0]                r_chan;
  logic [L2_AWIDTH_NOAL-1:0] r_addr;
  logic [TRANS_SIZE-1:0]     r_size;
  logic [1:0]                r_ds;
  logic                      r_wait;
  logic [c_PW-1:0]           r_poll_cnt;
  logic [c_GW-1:0]           r_gap_cnt;

  logic                      w_accept;
  logic                      w_rd_done;
  logic                      w_chan_idle;
  logic [4:0]                w_reg_saddr;
  logic [4:0]                w_reg_size;
  logic [4:0]                w_reg_cfg;
  logic                      w_unused;

  assign w_accept    = req_valid_i && (r_state == ST_IDLE);
  assign w_rd_done   = (r_state == ST_POLL_RD) && cfg.cfg_ready_i;
  // Channel has drained once both en (bit4) and pending (bit5) read back 0.
  assign w_chan_idle = (cfg.cfg_data_i[5:4] == 2'b00);
  assign w_unused    = ^{cfg.cfg_data_i[31:6], cfg.cfg_data_i[3:0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic; w_err_nxt is only set on a transition into DONE, so
  // r_err is high exactly while DONE reports a failure.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (req_chan_i == c_CHAN_ILLEGAL) begin
            w_state_nxt = ST_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_WR_SADDR;
          end
        end
      end
      ST_WR_SADDR: if (cfg.cfg_ready_i) w_state_nxt = ST_WR_SIZE;
      ST_WR_SIZE:  if (cfg.cfg_ready_i) w_state_nxt = ST_WR_CFG;
      ST_WR_CFG: begin
        if (cfg.cfg_ready_i) w_state_nxt = r_wait ? ST_POLL_RD : ST_DONE;
      end
      ST_POLL_RD: begin
        if (cfg.cfg_ready_i) begin
          if (w_chan_idle) begin
            w_state_nxt = ST_DONE;
          end else if (r_poll_cnt >= c_POLL_LAST) begin
            w_state_nxt = ST_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = c_HAS_GAP ? ST_GAP : ST_POLL_RD;
          end
        end
      end
      ST_GAP:  if (r_gap_cnt == c_GAP_LAST) w_state_nxt = ST_POLL_RD;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Descriptor latch and poll/gap counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_chan     <= 2'd0;
      r_addr     <= '0;
      r_size     <= '0;
      r_ds       <= 2'd0;
      r_wait     <= 1'b0;
      r_poll_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_chan     <= req_chan_i;
        r_addr     <= req_addr_i;
        r_size     <= req_size_i;
        r_ds       <= req_datasize_i;
        r_wait     <= req_wait_i;
        r_poll_cnt <= '0;
      end else if (w_rd_done && (r_poll_cnt != c_POLL_SAT)) begin
        r_poll_cnt <= r_poll_cnt + c_PW'(1);
      end

      if (r_state == ST_GAP) begin
        r_gap_cnt <= (r_gap_cnt == c_GAP_LAST) ? '0 : r_gap_cnt + c_GW'(1);
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register addresses for the latched channel
  // --------------------------------------------------------------------------
  always_comb begin
    w_reg_saddr = c_REG_CMD_SADDR;
    w_reg_size  = c_REG_CMD_SIZE;
    w_reg_cfg   = c_REG_CMD_CFG;
    case (r_chan)
      c_CHAN_RX: begin
        w_reg_saddr = c_REG_RX_SADDR;
        w_reg_size  = c_REG_RX_SIZE;
        w_reg_cfg   = c_REG_RX_CFG;
      end
      c_CHAN_TX: begin
        w_reg_saddr = c_REG_TX_SADDR;
        w_reg_size  = c_REG_TX_SIZE;
        w_reg_cfg   = c_REG_TX_CFG;
      end
      c_CHAN_CMD: begin
        w_reg_saddr = c_REG_CMD_SADDR;
        w_reg_size  = c_REG_CMD_SIZE;
        w_reg_cfg   = c_REG_CMD_CFG;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs decode from registered state and descriptor only
  // --------------------------------------------------------------------------
  always_comb begin
    cfg.cfg_valid_o = 1'b0;
    cfg.cfg_rwn_o   = 1'b1;
    cfg.cfg_addr_o  = 5'h00;
    cfg.cfg_data_o  = 32'h0;
    case (r_state)
      ST_WR_SADDR: begin
        cfg.cfg_valid_o = 1'b1;
        cfg.cfg_rwn_o   = 1'b0;
        cfg.cfg_addr_o  = w_reg_saddr;
        cfg.cfg_data_o  = 32'(r_addr);
      end
      ST_WR_SIZE: begin
        cfg.cfg_valid_o = 1'b1;
        cfg.cfg_rwn_o   = 1'b0;
        cfg.cfg_addr_o  = w_reg_size;
        cfg.cfg_data_o  = 32'(r_size);
      end
      ST_WR_CFG: begin
        // {clr=0, rsvd, en=1, rsvd, datasize, continuous=0}
        cfg.cfg_valid_o = 1'b1;
        cfg.cfg_rwn_o   = 1'b0;
        cfg.cfg_addr_o  = w_reg_cfg;
        cfg.cfg_data_o  = {25'h0, 1'b0, 1'b0, 1'b1, 1'b0, r_ds, 1'b0};
      end
      ST_POLL_RD: begin
        cfg.cfg_valid_o = 1'b1;
        cfg.cfg_rwn_o   = 1'b1;
        cfg.cfg_addr_o  = w_reg_cfg;
      end
      default: ;
    endcase
  end

  assign req_ready_o  = (r_state == ST_IDLE);
  assign busy_o       = (r_state != ST_IDLE);
  assign done_valid_o = (r_state == ST_DONE);
  assign done_err_o   = (r_state == ST_DONE) && r_err;

endmodule
`default_nettype wire
